// File: rtl/memory_access_unit_if.sv
// Data-memory request/response bus between the memory access unit and the data memory.
interface memory_access_unit_if;
   logic [31:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_re;
   logic        mem_we;
   logic [15:0] mem_rdata;
   logic        mem_ready;

   modport master (
      output mem_addr, mem_wdata, mem_re, mem_we,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_re, mem_we,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/memory_access_unit.sv
// MEM stage: sequences one- and two-beat data-memory accesses (load/store, PC and flags
// push/pop) over a ready handshake and produces a one-cycle registered writeback response.
module memory_access_unit (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        valid_i,
   input  logic [31:0]                 data_i,
   input  logic [31:0]                 address_i,
   input  logic                        mr_i,
   input  logic                        mw_i,
   input  logic                        wb_i,
   input  logic                        sp_i,
   input  logic                        spop_i,
   input  logic                        jwsp_i,
   input  logic                        stack_pc_i,
   input  logic                        stack_flags_i,
   input  logic [2:0]                  wb_address_i,
   input  logic [2:0]                  final_flags_i,
   memory_access_unit_if.master        mem_io,
   output logic                        stall_o,
   output logic                        done_o,
   output logic                        wb_out_o,
   output logic [2:0]                  wb_address_out_o,
   output logic [15:0]                 wb_data_o,
   output logic                        pc_load_o,
   output logic [31:0]                 pc_from_memory_o,
   output logic                        flags_load_o,
   output logic [2:0]                  flags_from_memory_o
);

   typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StResp} state_e;

   state_e      state_q, state_d;
   logic        read_q, read_d, pc_q, pc_d, flags_q, flags_d, wb_q, wb_d;
   logic [2:0]  wb_addr_q, wb_addr_d;
   logic [31:0] addr_q, addr_d;
   logic [15:0] data_lo_q, data_lo_d, low_q, low_d;

   logic [31:0] mem_addr_q, mem_addr_d, pc_from_memory_q, pc_from_memory_d;
   logic [15:0] mem_wdata_q, mem_wdata_d, wb_data_q, wb_data_d;
   logic        mem_re_q, mem_re_d, mem_we_q, mem_we_d;
   logic        done_q, done_d, wb_out_q, wb_out_d, pc_load_q, pc_load_d;
   logic        flags_load_q, flags_load_d;
   logic [2:0]  wb_address_out_q, wb_address_out_d, flags_from_memory_q, flags_from_memory_d;

   // Stack-pointer control bits are resolved upstream; the address arrives already selected.
   logic unused_inputs;
   assign unused_inputs = ^{sp_i, spop_i, jwsp_i};

   always_comb begin
      state_d             = state_q;
      read_d              = read_q;
      pc_d                = pc_q;
      flags_d             = flags_q;
      wb_d                = wb_q;
      wb_addr_d           = wb_addr_q;
      addr_d              = addr_q;
      data_lo_d           = data_lo_q;
      low_d               = low_q;
      mem_addr_d          = mem_addr_q;
      mem_wdata_d         = mem_wdata_q;
      mem_re_d            = 1'b0;
      mem_we_d            = 1'b0;
      done_d              = 1'b0;
      wb_out_d            = 1'b0;
      pc_load_d           = 1'b0;
      flags_load_d        = 1'b0;
      wb_address_out_d    = wb_address_out_q;
      wb_data_d           = wb_data_q;
      pc_from_memory_d    = pc_from_memory_q;
      flags_from_memory_d = flags_from_memory_q;

      unique case (state_q)
         StIdle: begin
            if (valid_i && (mr_i || mw_i)) begin
               state_d     = StBeat0;
               read_d      = mr_i;
               pc_d        = stack_pc_i;
               flags_d     = stack_flags_i && !stack_pc_i;
               wb_d        = wb_i;
               wb_addr_d   = wb_address_i;
               addr_d      = address_i;
               data_lo_d   = data_i[15:0];
               mem_re_d    = mr_i;
               mem_we_d    = !mr_i;
               mem_addr_d  = address_i;
               // PC push sends the high half first; flags push sends the zero-extended flags.
               if (stack_pc_i)         mem_wdata_d = data_i[31:16];
               else if (stack_flags_i) mem_wdata_d = {13'b0, final_flags_i};
               else                    mem_wdata_d = data_i[15:0];
            end else if (valid_i) begin
               done_d           = 1'b1;
               wb_out_d         = wb_i;
               wb_address_out_d = wb_address_i;
               wb_data_d        = data_i[15:0];
            end
         end
         StBeat0: begin
            mem_re_d = mem_re_q;
            mem_we_d = mem_we_q;
            if (mem_io.mem_ready) begin
               if (pc_q) begin
                  state_d     = StBeat1;
                  low_d       = mem_io.mem_rdata;
                  mem_addr_d  = read_q ? addr_q + 32'd1 : addr_q - 32'd1;
                  mem_wdata_d = data_lo_q;
               end else begin
                  state_d          = StResp;
                  mem_re_d         = 1'b0;
                  mem_we_d         = 1'b0;
                  done_d           = 1'b1;
                  wb_out_d         = wb_q && read_q;
                  wb_address_out_d = wb_addr_q;
                  if (read_q && flags_q) begin
                     flags_load_d        = 1'b1;
                     flags_from_memory_d = mem_io.mem_rdata[2:0];
                  end else if (read_q) begin
                     wb_data_d = mem_io.mem_rdata;
                  end
               end
            end
         end
         StBeat1: begin
            mem_re_d = mem_re_q;
            mem_we_d = mem_we_q;
            if (mem_io.mem_ready) begin
               state_d          = StResp;
               mem_re_d         = 1'b0;
               mem_we_d         = 1'b0;
               done_d           = 1'b1;
               wb_out_d         = wb_q && read_q;
               wb_address_out_d = wb_addr_q;
               if (read_q) begin
                  pc_load_d        = 1'b1;
                  pc_from_memory_d = {mem_io.mem_rdata, low_q};
               end
            end
         end
         StResp: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q             <= StIdle;
         read_q              <= 1'b0;
         pc_q                <= 1'b0;
         flags_q             <= 1'b0;
         wb_q                <= 1'b0;
         wb_addr_q           <= 3'd0;
         addr_q              <= 32'd0;
         data_lo_q           <= 16'd0;
         low_q               <= 16'd0;
         mem_addr_q          <= 32'd0;
         mem_wdata_q         <= 16'd0;
         mem_re_q            <= 1'b0;
         mem_we_q            <= 1'b0;
         done_q              <= 1'b0;
         wb_out_q            <= 1'b0;
         pc_load_q           <= 1'b0;
         flags_load_q        <= 1'b0;
         wb_address_out_q    <= 3'd0;
         wb_data_q           <= 16'd0;
         pc_from_memory_q    <= 32'd0;
         flags_from_memory_q <= 3'd0;
      end else begin
         state_q             <= state_d;
         read_q              <= read_d;
         pc_q                <= pc_d;
         flags_q             <= flags_d;
         wb_q                <= wb_d;
         wb_addr_q           <= wb_addr_d;
         addr_q              <= addr_d;
         data_lo_q           <= data_lo_d;
         low_q               <= low_d;
         mem_addr_q          <= mem_addr_d;
         mem_wdata_q         <= mem_wdata_d;
         mem_re_q            <= mem_re_d;
         mem_we_q            <= mem_we_d;
         done_q              <= done_d;
         wb_out_q            <= wb_out_d;
         pc_load_q           <= pc_load_d;
         flags_load_q        <= flags_load_d;
         wb_address_out_q    <= wb_address_out_d;
         wb_data_q           <= wb_data_d;
         pc_from_memory_q    <= pc_from_memory_d;
         flags_from_memory_q <= flags_from_memory_d;
      end
   end

   // Stall is the only combinational output; gated by reset so it reads 0 while held.
   assign stall_o = rst_n && ((state_q == StIdle && valid_i && (mr_i || mw_i)) ||
                              state_q == StBeat0 || state_q == StBeat1);

   assign mem_io.mem_addr     = mem_addr_q;
   assign mem_io.mem_wdata    = mem_wdata_q;
   assign mem_io.mem_re       = mem_re_q;
   assign mem_io.mem_we       = mem_we_q;
   assign done_o              = done_q;
   assign wb_out_o            = wb_out_q;
   assign wb_address_out_o    = wb_address_out_q;
   assign wb_data_o           = wb_data_q;
   assign pc_load_o           = pc_load_q;
   assign pc_from_memory_o    = pc_from_memory_q;
   assign flags_load_o        = flags_load_q;
   assign flags_from_memory_o = flags_from_memory_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: each transaction is driven one cycle at a time and
// the bus and response outputs are compared against hand-computed values.
module tb_memory_access_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic [31:0] data = '0;
   logic [31:0] address = '0;
   logic        mr = 1'b0, mw = 1'b0, wb = 1'b0, sp = 1'b0, spop = 1'b0, jwsp = 1'b0;
   logic        stack_pc = 1'b0, stack_flags = 1'b0;
   logic [2:0]  wb_address = '0, final_flags = '0;
   logic        stall, done, wb_out, pc_load, flags_load;
   logic [2:0]  wb_address_out, flags_from_memory;
   logic [15:0] wb_data;
   logic [31:0] pc_from_memory;

   int n_cmp = 0;
   int n_err = 0;

   memory_access_unit_if mem_bus ();

   memory_access_unit dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .valid_i             (valid),
      .data_i              (data),
      .address_i           (address),
      .mr_i                (mr),
      .mw_i                (mw),
      .wb_i                (wb),
      .sp_i                (sp),
      .spop_i              (spop),
      .jwsp_i              (jwsp),
      .stack_pc_i          (stack_pc),
      .stack_flags_i       (stack_flags),
      .wb_address_i        (wb_address),
      .final_flags_i       (final_flags),
      .mem_io              (mem_bus.master),
      .stall_o             (stall),
      .done_o              (done),
      .wb_out_o            (wb_out),
      .wb_address_out_o    (wb_address_out),
      .wb_data_o           (wb_data),
      .pc_load_o           (pc_load),
      .pc_from_memory_o    (pc_from_memory),
      .flags_load_o        (flags_load),
      .flags_from_memory_o (flags_from_memory)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Presents one EX/MEM entry for a single cycle, checking Stall in the sampling cycle.
   task automatic issue(input logic i_mr, input logic i_mw, input logic i_spc, input logic i_sfl,
                        input logic i_wb, input logic [2:0] i_wa, input logic [31:0] i_addr,
                        input logic [31:0] i_data, input logic [2:0] i_ff, input string tag);
      valid       = 1'b1;
      mr          = i_mr;
      mw          = i_mw;
      stack_pc    = i_spc;
      stack_flags = i_sfl;
      wb          = i_wb;
      wb_address  = i_wa;
      address     = i_addr;
      data        = i_data;
      final_flags = i_ff;
      #1;
      check_eq({tag, "_stall_sample"}, 32'(stall), 32'(i_mr | i_mw));
      tick();
      valid = 1'b0;
      mr = 1'b0; mw = 1'b0; stack_pc = 1'b0; stack_flags = 1'b0; wb = 1'b0;
   endtask

   initial begin
      mem_bus.mem_ready = 1'b0;
      mem_bus.mem_rdata = 16'h0;
      // Reset: outputs zero, and Stall suppressed even with a memory request presented.
      valid = 1'b1; mw = 1'b1;
      #3;
      check_eq("rst_stall", 32'(stall), 32'd0);
      check_eq("rst_we", 32'(mem_bus.mem_we), 32'd0);
      check_eq("rst_re", 32'(mem_bus.mem_re), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_addr", mem_bus.mem_addr, 32'd0);
      check_eq("rst_pc_load", 32'(pc_load), 32'd0);
      valid = 1'b0; mw = 1'b0;
      #10 rst_n = 1'b1;
      tick();

      // Store with Ready tied high; WB requested but a store never writes back.
      mem_bus.mem_ready = 1'b1;
      issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 32'h10, 32'h0000ABCD, 3'd0, "st");
      check_eq("st_we", 32'(mem_bus.mem_we), 32'd1);
      check_eq("st_re", 32'(mem_bus.mem_re), 32'd0);
      check_eq("st_addr", mem_bus.mem_addr, 32'h10);
      check_eq("st_wdata", 32'(mem_bus.mem_wdata), 32'hABCD);
      check_eq("st_stall_beat", 32'(stall), 32'd1);
      tick();
      check_eq("st_done", 32'(done), 32'd1);
      check_eq("st_wb_out", 32'(wb_out), 32'd0);
      check_eq("st_we_resp", 32'(mem_bus.mem_we), 32'd0);
      check_eq("st_stall_resp", 32'(stall), 32'd0);
      tick();
      check_eq("st_done_after", 32'(done), 32'd0);

      // Load with Ready low for three cycles.
      mem_bus.mem_ready = 1'b0;
      issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 32'h20, 32'h0, 3'd0, "ld");
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("ld_re_%0d", i), 32'(mem_bus.mem_re), 32'd1);
         check_eq($sformatf("ld_addr_%0d", i), mem_bus.mem_addr, 32'h20);
         check_eq($sformatf("ld_stall_%0d", i), 32'(stall), 32'd1);
         check_eq($sformatf("ld_done_%0d", i), 32'(done), 32'd0);
         if (i == 3) begin
            mem_bus.mem_ready = 1'b1;
            mem_bus.mem_rdata = 16'h1234;
         end
         tick();
      end
      check_eq("ld_done", 32'(done), 32'd1);
      check_eq("ld_wb_out", 32'(wb_out), 32'd1);
      check_eq("ld_wb_addr", 32'(wb_address_out), 32'd3);
      check_eq("ld_wb_data", 32'(wb_data), 32'h1234);
      check_eq("ld_re_resp", 32'(mem_bus.mem_re), 32'd0);
      check_eq("ld_stall_resp", 32'(stall), 32'd0);
      tick();
      check_eq("ld_done_after", 32'(done), 32'd0);
      check_eq("ld_wb_out_after", 32'(wb_out), 32'd0);

      // PC push: high half at Address, low half at Address-1.
      issue(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h7FF, 32'h00012345, 3'd0, "push");
      check_eq("push_b0_we", 32'(mem_bus.mem_we), 32'd1);
      check_eq("push_b0_addr", mem_bus.mem_addr, 32'h7FF);
      check_eq("push_b0_wdata", 32'(mem_bus.mem_wdata), 32'h0001);
      tick();
      check_eq("push_b1_we", 32'(mem_bus.mem_we), 32'd1);
      check_eq("push_b1_addr", mem_bus.mem_addr, 32'h7FE);
      check_eq("push_b1_wdata", 32'(mem_bus.mem_wdata), 32'h2345);
      check_eq("push_b1_stall", 32'(stall), 32'd1);
      tick();
      check_eq("push_done", 32'(done), 32'd1);
      check_eq("push_pc_load", 32'(pc_load), 32'd0);
      check_eq("push_we_resp", 32'(mem_bus.mem_we), 32'd0);
      tick();

      // PC pop across the address wrap.
      mem_bus.mem_rdata = 16'h5678;
      issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'hFFFFFFFF, 32'h0, 3'd0, "pop");
      check_eq("pop_b0_re", 32'(mem_bus.mem_re), 32'd1);
      check_eq("pop_b0_addr", mem_bus.mem_addr, 32'hFFFFFFFF);
      tick();
      check_eq("pop_b1_re", 32'(mem_bus.mem_re), 32'd1);
      check_eq("pop_b1_addr", mem_bus.mem_addr, 32'h0);
      check_eq("pop_b1_pc_load", 32'(pc_load), 32'd0);
      mem_bus.mem_rdata = 16'h0009;
      tick();
      check_eq("pop_done", 32'(done), 32'd1);
      check_eq("pop_pc_load", 32'(pc_load), 32'd1);
      check_eq("pop_pc", pc_from_memory, 32'h00095678);
      tick();
      check_eq("pop_pc_load_after", 32'(pc_load), 32'd0);

      // Flags push and pop, then MR=MW=1 treated as a read.
      issue(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'h300, 32'h0, 3'b110, "fpush");
      check_eq("fpush_wdata", 32'(mem_bus.mem_wdata), 32'h0006);
      check_eq("fpush_we", 32'(mem_bus.mem_we), 32'd1);
      tick();
      check_eq("fpush_flags_load", 32'(flags_load), 32'd0);
      tick();
      mem_bus.mem_rdata = 16'hFFF5;
      issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h300, 32'h0, 3'd0, "fpop");
      check_eq("fpop_re", 32'(mem_bus.mem_re), 32'd1);
      tick();
      check_eq("fpop_flags_load", 32'(flags_load), 32'd1);
      check_eq("fpop_flags", 32'(flags_from_memory), 32'h5);
      check_eq("fpop_done", 32'(done), 32'd1);
      tick();
      check_eq("fpop_flags_load_after", 32'(flags_load), 32'd0);
      issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h40, 32'h0, 3'd0, "rw");
      check_eq("rw_re", 32'(mem_bus.mem_re), 32'd1);
      check_eq("rw_we", 32'(mem_bus.mem_we), 32'd0);
      tick();
      check_eq("rw_done", 32'(done), 32'd1);
      tick();

      // No memory access: response next cycle, no stall.
      issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 32'h0, 32'h0000BEEF, 3'd0, "alu");
      check_eq("alu_done", 32'(done), 32'd1);
      check_eq("alu_wb_out", 32'(wb_out), 32'd1);
      check_eq("alu_wb_addr", 32'(wb_address_out), 32'd5);
      check_eq("alu_wb_data", 32'(wb_data), 32'hBEEF);
      check_eq("alu_re", 32'(mem_bus.mem_re), 32'd0);
      check_eq("alu_we", 32'(mem_bus.mem_we), 32'd0);
      tick();
      check_eq("alu_done_after", 32'(done), 32'd0);

      // Reset asserted during BEAT1 of a PC push.
      issue(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h100, 32'hCAFE0001, 3'd0, "rpush");
      tick();
      check_eq("rpush_b1_we", 32'(mem_bus.mem_we), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rpush_we_async", 32'(mem_bus.mem_we), 32'd0);
      check_eq("rpush_stall_async", 32'(stall), 32'd0);
      tick();
      check_eq("rpush_done_rst", 32'(done), 32'd0);
      check_eq("rpush_pc_load_rst", 32'(pc_load), 32'd0);
      #3 rst_n = 1'b1;
      tick();
      check_eq("rpush_we_after", 32'(mem_bus.mem_we), 32'd0);
      check_eq("rpush_stall_after", 32'(stall), 32'd0);
      check_eq("rpush_done_after", 32'(done), 32'd0);
      tick();
      check_eq("rpush_we_after2", 32'(mem_bus.mem_we), 32'd0);
      check_eq("rpush_done_after2", 32'(done), 32'd0);
      check_eq("rpush_pc_load_after2", 32'(pc_load), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 SHALL have one clock and one reset: asynchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 Valid  in  1  EX/MEM entry holds a live instruction.
REQ-005 Data  in  32  store data, or full PC on PC push; WB data otherwise.
REQ-006 Address  in  32  word address: stack pointer or operand.
REQ-007 MR, MW, WB, SP, SPOP, JWSP, Stack_PC, Stack_Flags  in  1 each  EX/MEM control bits.
REQ-008 WB_Address  in  3  destination register; Final_Flags  in  3  {NF,CF,ZF}.
REQ-009 Mem_Addr  out  32, Mem_WData  out  16, Mem_RE  out  1, Mem_WE  out  1  data-memory request.
REQ-010 Mem_RData  in  16, Mem_Ready  in  1  memory completes the current beat when high.
REQ-011 Stall  out  1  holds IF/ID/EX and the EX/MEM buffer.
REQ-012 Done  out  1  one-cycle MEM/WB valid.
REQ-013 WB_Out  out  1, WB_Address_Out  out  3, WB_Data  out  16  writeback result.
REQ-014 PC_Load  out  1, PC_From_Memory  out  32  popped return PC.
REQ-015 Flags_Load  out  1, Flags_From_Memory  out  3  popped flags {NF,CF,ZF}.

Function
REQ-016 SHALL implement the states IDLE, BEAT0, BEAT1 and RESP; all outputs except Stall SHALL be registered.
REQ-017 IDLE, Valid and (MR or MW): capture all inputs; go to BEAT0; Stall=1 in that cycle.
REQ-018 IDLE, Valid with MR=MW=0: the next cycle gives Done=1, WB_Out=WB, WB_Data=Data[15:0] and no memory access; Stall=0.
REQ-019 MR=MW=1 SHALL be handled as a read; MW is ignored.
REQ-020 BEAT0/BEAT1: SHALL hold Mem_RE or Mem_WE, Mem_Addr and Mem_WData stable until a cycle with Mem_Ready=1; exactly one of RE/WE is high.
REQ-021 Single-beat operations are plain load, plain store, flags push and flags pop: BEAT0 + Ready -> RESP.
REQ-022 Two-beat operations have Stack_PC=1: BEAT0 + Ready -> BEAT1; BEAT1 + Ready -> RESP.
REQ-023 Plain store: Mem_Addr=Address, Mem_WData=Data[15:0].
REQ-024 Plain load: Mem_Addr=Address; in RESP, WB_Data=Mem_RData as sampled on Ready.
REQ-025 Flags push (Stack_Flags and MW): Mem_WData={13'b0,Final_Flags}.
REQ-026 Flags pop (Stack_Flags and MR): in RESP, Flags_Load=1 and Flags_From_Memory=RData[2:0].
REQ-027 PC push: BEAT0 writes Data[31:16] at Address; BEAT1 writes Data[15:0] at Address-1.
REQ-028 PC pop: BEAT0 reads the low word at Address; BEAT1 reads the high word at Address+1.
REQ-029 PC pop: in RESP, PC_Load=1 and PC_From_Memory={high,low}.
REQ-030 Address+1 and Address-1 SHALL be computed modulo 2^32: 0xFFFFFFFF+1 gives 0, and 0-1 gives 0xFFFFFFFF.
REQ-031 Stall SHALL be 1 in BEAT0 and BEAT1, and SHALL be 0 in RESP and in IDLE except as given in REQ-017.
REQ-032 RESP SHALL last exactly one cycle with Done=1, WB_Out=WB and WB_Address_Out=WB_Address; stores give WB_Out=0.
REQ-033 RESP -> IDLE; a new Valid entry presented in RESP SHALL be sampled in the following IDLE cycle.
REQ-034 Done, PC_Load, Flags_Load and WB_Out SHALL be 0 in every cycle other than the response cycle.
REQ-035 Mem_Ready while IDLE or RESP SHALL be ignored.
REQ-036 Mem_RE and Mem_WE SHALL be 0 in IDLE and RESP.
REQ-037 Mem_Ready held at 0 SHALL hold the state indefinitely, with no timeout.

Reset
REQ-038 rst_n=0 SHALL immediately force state IDLE and drive every output to 0, with Mem_WE=0 asynchronously, including mid-beat.
REQ-039 An access interrupted by reset SHALL be discarded and not replayed.
REQ-040 The first rising edge with rst_n=1 SHALL evaluate IDLE normally.

Verification
REQ-041 Store, Address=0x10, Data=0x0000ABCD, Ready tied 1 -> one WE beat at addr 0x10 with data 0xABCD; Stall high 2 cycles; Done with WB_Out=0.
REQ-042 Load, Address=0x20, Ready low 3 cycles, RData=0x1234 -> RE held 4 cycles with stable addr; WB_Data=0x1234; Stall high throughout.
REQ-043 PC push, Address=0x7FF, Data=0x00012345 -> write 0x0001@0x7FF, then 0x2345@0x7FE.
REQ-044 PC pop, Address=0xFFFFFFFF, RData 0x5678 then 0x0009 -> reads at 0xFFFFFFFF then 0x0; PC_Load=1; PC_From_Memory=0x00095678.
REQ-045 Flags pop, RData=0xFFF5 -> Flags_Load=1 and Flags_From_Memory=3'b101; then MR=MW=1 -> a read only.
REQ-046 rst_n low during the BEAT1 of a PC push -> Mem_WE drops at once; IDLE after release; PC_Load and Done stay 0.
